// File: rtl/bmm_sequencer.sv
// Job controller for an NxN boolean OR-AND systolic array: skews operand beats in,
// flushes the pipeline, sequences the readout shift and streams the buffered result rows.
module bmm_sequencer #(
  parameter int unsigned N  = 8,
  parameter int unsigned KW = 8,
  localparam int unsigned RW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [KW-1:0] k_len,
  output logic          busy,
  output logic          done,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [N-1:0]  op_a,
  input  logic [N-1:0]  op_b,
  output logic [N-1:0]  arr_in1,
  output logic [N-1:0]  arr_in2,
  output logic          arr_readout,
  input  logic [N-1:0]  arr_out,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [N-1:0]  res_data,
  output logic [RW-1:0] res_row,
  output logic          res_last
);

  localparam int unsigned CW = $clog2(2 * N);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_FLUSH,
    S_READ,
    S_DRAIN
  } state_t;

  state_t        state, state_n;
  logic [KW-1:0] k_q, beat_cnt;
  logic [CW-1:0] seq_cnt;
  logic          beat, hs;
  logic [N-1:0]  inj_a, inj_b;
  logic [RW-1:0] cap_row;
  logic [N-1:0]  rbuf [N];

  // Next state, beat/handshake strobes and injected lane values
  always_comb begin
    state_n = state;
    beat    = 1'b0;
    hs      = 1'b0;
    inj_a   = '0;
    inj_b   = '0;
    cap_row = RW'(N - 1) - RW'(seq_cnt >> 1);
    case (state)
      S_IDLE: begin
        if (start) state_n = (k_len == '0) ? S_FLUSH : S_FEED;
      end
      S_FEED: begin
        beat = op_valid & op_ready;
        if (beat) begin
          inj_a = op_a;
          inj_b = op_b;
          if (beat_cnt == k_q - KW'(1)) state_n = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (seq_cnt == CW'(2 * N - 2)) state_n = S_READ;
      end
      S_READ: begin
        if (seq_cnt == CW'(2 * N - 1)) state_n = S_DRAIN;
      end
      S_DRAIN: begin
        hs = res_valid & res_ready;
        if (hs && res_last) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Counters, row buffer and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      op_ready    <= 1'b0;
      arr_readout <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_row     <= '0;
      res_last    <= 1'b0;
      k_q         <= '0;
      beat_cnt    <= '0;
      seq_cnt     <= '0;
      for (int r = 0; r < N; r++) rbuf[r] <= '0;
    end else begin
      busy        <= (state_n != S_IDLE);
      op_ready    <= (state_n == S_FEED);
      arr_readout <= (state_n == S_READ);
      done        <= hs & res_last;

      if (state == S_IDLE && start) begin
        k_q      <= k_len;
        beat_cnt <= '0;
      end else if (beat) begin
        beat_cnt <= beat_cnt + KW'(1);
      end

      if (state_n != state)                      seq_cnt <= '0;
      else if (state == S_FLUSH || state == S_READ) seq_cnt <= seq_cnt + CW'(1);

      // Odd readout cycles present the next row at the bottom of the array
      if (state == S_READ && seq_cnt[0]) rbuf[cap_row] <= arr_out;

      if (state == S_READ && state_n == S_DRAIN) begin
        res_valid <= 1'b1;
        res_row   <= RW'(N - 1);
        res_data  <= rbuf[N-1];
        res_last  <= (N == 1);
      end else if (hs) begin
        if (res_last) begin
          res_valid <= 1'b0;
          res_last  <= 1'b0;
          res_data  <= '0;
          res_row   <= '0;
        end else begin
          res_row  <= res_row - RW'(1);
          res_data <= rbuf[res_row - RW'(1)];
          res_last <= (res_row == RW'(1));
        end
      end
    end
  end

  // Lane l sits behind l+1 registers so step k meets cell(i,j) after k+i+j cycles
  for (genvar l = 0; l < N; l++) begin : g_skew
    localparam int unsigned LW = l + 1;
    logic [LW-1:0] line_a, line_b;

    always_ff @(posedge clk) begin
      if (reset) begin
        line_a <= '0;
        line_b <= '0;
      end else begin
        line_a <= LW'({line_a, inj_a[l]});
        line_b <= LW'({line_b, inj_b[l]});
      end
    end

    assign arr_in2[l] = line_a[LW-1];
    assign arr_in1[l] = line_b[LW-1];
  end

endmodule

// File: tb/tb_bmm_sequencer.sv
// Bench for bmm_sequencer: behavioural OR-AND systolic array, directed jobs,
// scoreboard of expected result rows checked by an independent monitor.
module tb_bmm_sequencer;

  localparam int unsigned N  = 8;
  localparam int unsigned KW = 8;
  localparam int unsigned RW = 3;

  logic          clk;
  logic          reset;
  logic          start;
  logic [KW-1:0] k_len;
  logic          busy, done;
  logic          op_valid, op_ready;
  logic [N-1:0]  op_a, op_b;
  logic [N-1:0]  arr_in1, arr_in2;
  logic          arr_readout;
  logic [N-1:0]  arr_out;
  logic          res_valid, res_ready;
  logic [N-1:0]  res_data;
  logic [RW-1:0] res_row;
  logic          res_last;

  bmm_sequencer #(.N(N), .KW(KW)) dut (
    .clk(clk), .reset(reset), .start(start), .k_len(k_len), .busy(busy), .done(done),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .arr_in1(arr_in1), .arr_in2(arr_in2), .arr_readout(arr_readout), .arr_out(arr_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_row(res_row), .res_last(res_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]  data;
    logic [RW-1:0] row;
    logic          last;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   stall_cnt = 0;
  logic arr_init;

  // Array model: in1 flows down, in2 flows right; readout shifts accumulators down two hops per row
  logic [N-1:0] acc [N];
  logic [N-1:0] o1  [N];
  logic [N-1:0] o2  [N];

  function automatic logic from_up(input int i, input int j);
    if (i == 0) return arr_in1[j];
    return o1[i-1][j];
  endfunction

  function automatic logic from_left(input int i, input int j);
    if (j == 0) return arr_in2[i];
    return o2[i][j-1];
  endfunction

  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (arr_init) begin
          acc[i][j] <= 1'b0;
          o1[i][j]  <= 1'b0;
          o2[i][j]  <= 1'b0;
        end else if (arr_readout) begin
          o1[i][j]  <= acc[i][j];
          acc[i][j] <= from_up(i, j);
          o2[i][j]  <= 1'b0;
        end else begin
          o1[i][j]  <= from_up(i, j);
          o2[i][j]  <= from_left(i, j);
          acc[i][j] <= acc[i][j] | (from_up(i, j) & from_left(i, j));
        end
      end
    end
  end

  assign arr_out = o1[N-1];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out", name);
  endtask

  // Hand-derived rows: identity jobs give C row r = 1<<r, all-ones jobs give FF, K=0 gives 00
  function automatic logic [N-1:0] exp_row(input int mode, input int k, input int r);
    if (k == 0)    return '0;
    if (mode == 1) return '1;
    return N'(1) << r;
  endfunction

  // Result consumer: stalls when asked, otherwise always ready
  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_cnt > 0 && res_valid) begin
        res_ready = 1'b0;
        stall_cnt--;
      end else begin
        res_ready = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on each result handshake, checks hold and done pulse
  initial begin
    logic pend_done;
    logic held_v;
    exp_t held, cur, e;
    pend_done = 1'b0;
    held_v    = 1'b0;
    held      = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend_done = 1'b0;
        held_v    = 1'b0;
      end else begin
        cur = exp_t'({res_data, res_row, res_last});
        check("done_pulse", int'(done), int'(pend_done));
        if (held_v) begin
          check("hold_valid", int'(res_valid), 1);
          check("hold_payload", int'(cur), int'(held));
        end
        held_v    = res_valid && !res_ready;
        held      = cur;
        pend_done = res_valid && res_ready && res_last;
        if (res_valid && res_ready) begin
          if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_row: got row %0d data %0h want none", res_row, res_data);
          end else begin
            e = sb_q.pop_front();
            check("res_row", int'(res_row), int'(e.row));
            check("res_data", int'(res_data), int'(e.data));
            check("res_last", int'(res_last), int'(e.last));
          end
        end
      end
    end
  end

  // One job: mode 0 identity, 1 all-ones, 2 K=0 with junk operands held valid
  task automatic run_job(input int k, input int mode, input bit bubbles, input bit poke,
                         output int cyc);
    time  t0;
    int   b, guard;
    bit   phase, hs_beat;
    exp_t e;
    for (int r = N - 1; r >= 0; r--) begin
      e.data = exp_row(mode, k, r);
      e.row  = RW'(r);
      e.last = (r == 0);
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b1;
    k_len = KW'(k);
    t0    = $time;
    if (mode == 2) begin
      op_valid = 1'b1;
      op_a     = '1;
      op_b     = '1;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    b     = 0;
    guard = 0;
    phase = 1'b0;
    while (b < k && guard < 4 * k + 20) begin
      op_valid = !(bubbles && phase);
      phase    = !phase;
      op_a     = (mode == 1) ? '1 : N'(1) << b;
      op_b     = (mode == 1) ? '1 : N'(1) << b;
      start    = poke && (guard == 3);
      if (poke && guard == 3) k_len = '0;
      @(negedge clk);
      hs_beat = op_valid && op_ready;
      @(posedge clk);
      #1;
      if (hs_beat) b++;
      guard++;
    end
    start = 1'b0;
    if (b < k) fail_now("feed_beats");
    if (mode != 2) begin
      op_valid = 1'b0;
      op_a     = '0;
      op_b     = '0;
    end
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!done && guard < 2000);
    if (!done) fail_now("done_wait");
    cyc      = int'(($time - t0) / 10);
    op_valid = 1'b0;
    op_a     = '0;
    op_b     = '0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    reset    = 1'b1;
    arr_init = 1'b1;
    start    = 1'b0;
    k_len    = '0;
    op_valid = 1'b0;
    op_a     = '0;
    op_b     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_op_ready", int'(op_ready), 0);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_res_last", int'(res_last), 0);
    check("rst_res_data", int'(res_data), 0);
    check("rst_res_row", int'(res_row), 0);
    check("rst_arr_in1", int'(arr_in1), 0);
    check("rst_arr_in2", int'(arr_in2), 0);
    check("rst_arr_readout", int'(arr_readout), 0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    arr_init = 1'b0;

    // Identity job, K=8
    run_job(8, 0, 1'b0, 1'b0, cyc);
    check_range("t1_latency", cyc, 8 + 5 * N - 1 - 2, 8 + 5 * N - 1 + 2);

    // K=0 with junk operands offered outside FEED
    run_job(0, 2, 1'b0, 1'b0, cyc);
    check_range("t2_latency", cyc, 5 * N - 1 - 2, 5 * N - 1 + 2);

    // Bubbles every other cycle, plus a start while busy
    run_job(8, 0, 1'b1, 1'b1, cyc);

    // Consumer stalls 20 cycles at the head of DRAIN
    stall_cnt = 20;
    run_job(8, 0, 1'b0, 1'b0, cyc);
    check("t4_stall_used", stall_cnt, 0);
    check_range("t4_latency", cyc, 8 + 5 * N - 1 + 20 - 2, 8 + 5 * N - 1 + 20 + 2);

    // Abort after three beats, then a clean identity job
    @(posedge clk);
    #1;
    start = 1'b1;
    k_len = KW'(8);
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      op_valid = 1'b1;
      op_a     = N'(1) << b;
      op_b     = N'(1) << b;
      @(negedge clk);
      check("t5_op_ready", int'(op_ready), 1);
      @(posedge clk);
      #1;
    end
    reset    = 1'b1;
    op_valid = 1'b0;
    op_a     = '0;
    op_b     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t5_busy", int'(busy), 0);
    check("t5_op_ready_rst", int'(op_ready), 0);
    check("t5_arr_in1", int'(arr_in1), 0);
    check("t5_arr_in2", int'(arr_in2), 0);
    check("t5_readout", int'(arr_readout), 0);
    check("t5_res_valid", int'(res_valid), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_job(8, 0, 1'b0, 1'b0, cyc);
    check_range("t5_latency", cyc, 8 + 5 * N - 1 - 2, 8 + 5 * N - 1 + 2);

    // Back-to-back: all-ones K=4, then identity
    run_job(4, 1, 1'b0, 1'b0, cyc);
    check_range("t6a_latency", cyc, 4 + 5 * N - 1 - 2, 4 + 5 * N - 1 + 2);
    run_job(8, 0, 1'b0, 1'b0, cyc);

    repeat (3) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    check("end_busy", int'(busy), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
